// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: writeback selects, funct3 access codes,
// sequencer states and the alignment check.
package mem_stage_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data-memory port: store replication and byte enables,
// load extraction with sign or zero extension.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] load_word,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data
);

    logic [WIDTH-1:0] shifted_s;

    assign shifted_s = load_word >> {addr_lo, 3'b000};

    // Store lane replication and byte-enable generation
    always_comb begin
        be    = 4'h0;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                be    = 4'hF;
                wdata = store_data;
            end
            default: begin
                be    = 4'h0;
                wdata = store_data;
            end
        endcase
    end

    // Load extraction and extension
    always_comb begin
        load_data = shifted_s;
        case (funct3)
            F3_B:    load_data = {{(WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{(WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_BU:   load_data = {{(WIDTH-8){1'b0}}, shifted_s[7:0]};
            F3_HU:   load_data = {{(WIDTH-16){1'b0}}, shifted_s[15:0]};
            F3_W:    load_data = shifted_s;
            default: load_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: sequences aligned loads/stores over a valid/ready data-memory port,
// stalls upstream while a request is outstanding and drives the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [WIDTH-1:0]    alu_out_i,
    input  logic [WIDTH-1:0]    rs2_data_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rf_w_en_i,
    input  logic [1:0]          wbsel_i,
    input  logic                mem_w_en_i,
    input  logic [2:0]          funct3_i,
    output logic                stall_o,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_LEN-1:0] dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic                dmem_ready,
    input  logic                dmem_rvalid,
    input  logic [WIDTH-1:0]    dmem_rdata,
    output logic                valid_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [WIDTH-1:0]    alu_out_o,
    output logic [WIDTH-1:0]    mem_rdata_o,
    output logic [4:0]          rd_addr_o,
    output logic                rf_w_en_o,
    output logic [1:0]          wbsel_o,
    output logic                misalign_o
);

    state_t           state_r;
    logic [WIDTH-1:0] rdata_r;
    logic [WIDTH-1:0] load_data_s;
    logic             mem_op_s;
    logic             is_load_s;
    logic             misalign_s;
    logic             go_s;
    logic             stall_s;

    assign mem_op_s   = in_valid & (mem_w_en_i | (wbsel_i == WB_MEM));
    assign is_load_s  = (wbsel_i == WB_MEM) & ~mem_w_en_i;
    assign misalign_s = mem_op_s & is_misaligned(funct3_i, alu_out_i[1:0]);
    assign go_s       = mem_op_s & ~misalign_s;
    // Held low during reset so upstream is released together with the stage.
    assign stall_s    = ~reset & go_s & (state_r != S_DONE);
    assign stall_o    = stall_s;

    assign dmem_req   = (state_r == S_REQ);
    assign dmem_we    = mem_w_en_i;
    assign dmem_addr  = {alu_out_i[ADDR_LEN-1:2], 2'b00};

    mem_align #(.WIDTH(WIDTH)) u_align (
        .addr_lo    (alu_out_i[1:0]),
        .funct3     (funct3_i),
        .store_data (rs2_data_i),
        .load_word  (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data_s)
    );

    // Request sequencer and load-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            rdata_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: if (go_s) state_r <= S_REQ;
                S_REQ:  if (dmem_ready) state_r <= mem_w_en_i ? S_DONE : S_RESP;
                S_RESP: begin
                    if (dmem_rvalid) begin
                        rdata_r <= load_data_s;
                        state_r <= S_DONE;
                    end
                end
                S_DONE:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise take the EX/MEM contents
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o     <= 1'b0;
            pc_o        <= '0;
            alu_out_o   <= '0;
            mem_rdata_o <= '0;
            rd_addr_o   <= 5'd0;
            rf_w_en_o   <= 1'b0;
            wbsel_o     <= 2'd0;
            misalign_o  <= 1'b0;
        end else begin
            pc_o      <= pc_i;
            alu_out_o <= alu_out_i;
            rd_addr_o <= rd_addr_i;
            wbsel_o   <= wbsel_i;
            if (stall_s) begin
                valid_o     <= 1'b0;
                rf_w_en_o   <= 1'b0;
                misalign_o  <= 1'b0;
                mem_rdata_o <= '0;
            end else begin
                valid_o     <= in_valid;
                rf_w_en_o   <= in_valid & rf_w_en_i & ~misalign_s;
                misalign_o  <= misalign_s;
                mem_rdata_o <= (is_load_s && (state_r == S_DONE)) ? rdata_r : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-edge ops plus hand-built memory transactions.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc_i, alu_out_i, rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        rf_w_en_i;
    logic [1:0]  wbsel_i;
    logic        mem_w_en_i;
    logic [2:0]  funct3_i;
    logic        stall_o, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        valid_o;
    logic [31:0] pc_o, alu_out_o, mem_rdata_o;
    logic [4:0]  rd_addr_o;
    logic        rf_w_en_o;
    logic [1:0]  wbsel_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_i(pc_i), .alu_out_i(alu_out_i),
        .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i), .rf_w_en_i(rf_w_en_i),
        .wbsel_i(wbsel_i), .mem_w_en_i(mem_w_en_i), .funct3_i(funct3_i), .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .valid_o(valid_o), .pc_o(pc_o), .alu_out_o(alu_out_o),
        .mem_rdata_o(mem_rdata_o), .rd_addr_o(rd_addr_o), .rf_w_en_o(rf_w_en_o),
        .wbsel_o(wbsel_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic rfw,
                         input logic [1:0] ws, input logic mw, input logic [2:0] f3);
        in_valid = iv; pc_i = pc; alu_out_i = a; rs2_data_i = rs2; rd_addr_i = rd;
        rf_w_en_i = rfw; wbsel_i = ws; mem_w_en_i = mw; funct3_i = f3;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, WB_ALU, 1'b0, F3_W);
    endtask

    // One memory transaction from presentation to MEM/WB, with bounded wait.
    task automatic mem_txn(input string nm, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rs2,
                           input logic [31:0] word, input int rwait, input int exp_stalls,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        int  stalls = 0;
        int  reqs   = 0;
        bit  pend   = 1'b0;
        bit  fin    = 1'b0;
        drive(1'b1, 32'h0000_0100, a, rs2, 5'd7, ~st, st ? WB_ALU : WB_MEM, st, f3);
        dmem_rdata = word;
        for (int c = 0; c < 40 && !fin; c++) begin
            dmem_rvalid = pend;
            pend = 1'b0;
            #1;
            if (dmem_req) begin
                chk({nm, "_addr"}, dmem_addr, exp_addr);
                if (reqs == 0) begin
                    chk({nm, "_we"}, {31'd0, dmem_we}, {31'd0, st});
                    if (st) begin
                        chk({nm, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                        chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
                    end
                end
                dmem_ready = (reqs >= rwait);
                reqs++;
                if (dmem_ready && !st) pend = 1'b1;
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (stall_o) stalls++;
            else fin = 1'b1;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            dmem_rvalid = 1'b0;
        end
        chk({nm, "_done"}, {31'd0, fin}, 32'd1);
        chk({nm, "_stalls"}, stalls, exp_stalls);
        chk({nm, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({nm, "_misalign"}, {31'd0, misalign_o}, 32'd0);
        chk({nm, "_rfw"}, {31'd0, rf_w_en_o}, {31'd0, ~st});
        chk({nm, "_alu"}, alu_out_o, a);
        if (!st) chk({nm, "_rdata"}, mem_rdata_o, exp_load);
        bubble();
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] a;
        logic [4:0]  rd;
        logic        rfw;
        logic [1:0]  ws;
        logic        mw;
        logic [2:0]  f3;
        logic        ev;
        logic        erf;
        logic        emis;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // iv  pc            a             rd     rfw   wbsel   mw    f3     ev    erf   emis
        vecs[0] = '{1'b1, 32'h0000_0040, 32'h0000_1234, 5'd1,  1'b1, WB_ALU, 1'b0, F3_W,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 5'd5,  1'b1, WB_PC4, 1'b0, F3_B,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0048, 32'h0000_3001, 5'd6,  1'b1, WB_MEM, 1'b0, F3_W,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_004C, 32'h0000_3001, 5'd9,  1'b1, WB_MEM, 1'b0, F3_W,  1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0050, 32'h0000_2003, 5'd10, 1'b1, WB_MEM, 1'b0, F3_H,  1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0054, 32'h0000_4002, 5'd0,  1'b0, WB_ALU, 1'b1, F3_W,  1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0058, 32'h0000_4001, 5'd0,  1'b0, WB_ALU, 1'b1, F3_H,  1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_005C, 32'h0000_0055, 5'd12, 1'b0, WB_ALU, 1'b0, F3_W,  1'b1, 1'b0, 1'b0};

        reset = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        bubble();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        reset = 1'b0;

        // Single-edge ops: ALU, PC+4, bubble, misaligned loads/stores
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].a, 32'h0, vecs[i].rd, vecs[i].rfw,
                  vecs[i].ws, vecs[i].mw, vecs[i].f3);
            #1;
            chk("tbl_stall", {31'd0, stall_o}, 32'd0);
            chk("tbl_req", {31'd0, dmem_req}, 32'd0);
            @(posedge clk); #1;
            chk("tbl_valid", {31'd0, valid_o}, {31'd0, vecs[i].ev});
            chk("tbl_alu", alu_out_o, vecs[i].a);
            chk("tbl_pc", pc_o, vecs[i].pc);
            chk("tbl_rd", {27'd0, rd_addr_o}, {27'd0, vecs[i].rd});
            chk("tbl_wbsel", {30'd0, wbsel_o}, {30'd0, vecs[i].ws});
            chk("tbl_rfw", {31'd0, rf_w_en_o}, {31'd0, vecs[i].erf});
            chk("tbl_misalign", {31'd0, misalign_o}, {31'd0, vecs[i].emis});
        end
        bubble();
        @(posedge clk); #1;

        // Stores and loads through the memory port
        mem_txn("sb",   1'b1, F3_B,  32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 2,
                32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
        mem_txn("sh",   1'b1, F3_H,  32'h0000_1002, 32'h1234_5678, 32'h0, 0, 2,
                32'h0000_1000, 4'b1100, 32'h5678_5678, 32'h0);
        mem_txn("sw",   1'b1, F3_W,  32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 0, 2,
                32'h0000_1008, 4'hF, 32'hDEAD_BEEF, 32'h0);
        mem_txn("lh",   1'b0, F3_H,  32'h0000_2002, 32'h0, 32'h8001_5555, 0, 3,
                32'h0000_2000, 4'h0, 32'h0, 32'hFFFF_8001);
        mem_txn("lhu",  1'b0, F3_HU, 32'h0000_2002, 32'h0, 32'h8001_5555, 0, 3,
                32'h0000_2000, 4'h0, 32'h0, 32'h0000_8001);
        mem_txn("lb",   1'b0, F3_B,  32'h0000_1001, 32'h0, 32'h1234_F678, 0, 3,
                32'h0000_1000, 4'h0, 32'h0, 32'hFFFF_FFF6);
        mem_txn("lbu",  1'b0, F3_BU, 32'h0000_1003, 32'h0, 32'h1234_F678, 0, 3,
                32'h0000_1000, 4'h0, 32'h0, 32'h0000_0012);
        mem_txn("lw_w", 1'b0, F3_W,  32'h0000_3004, 32'h0, 32'hCAFE_BABE, 5, 8,
                32'h0000_3004, 4'h0, 32'h0, 32'hCAFE_BABE);

        // Reset for two cycles while a load waits for ready
        drive(1'b1, 32'h0000_0200, 32'h0000_7000, 32'h0, 5'd4, 1'b1, WB_MEM, 1'b0, F3_W);
        @(posedge clk); #1;
        chk("mid_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
            chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
            chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
            chk("mid_rst_alu", alu_out_o, 32'h0);
            chk("mid_rst_pc", pc_o, 32'h0);
            chk("mid_rst_rd", {27'd0, rd_addr_o}, 32'd0);
        end
        reset = 1'b0;
        bubble();
        @(posedge clk); #1;

        // Reset while waiting for load data; the late response must be dropped
        drive(1'b1, 32'h0000_0300, 32'h0000_6000, 32'h0, 5'd3, 1'b1, WB_MEM, 1'b0, F3_W);
        dmem_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        #1;
        chk("resp_req", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("resp_stall", {31'd0, stall_o}, 32'd1);
        chk("resp_noreq", {31'd0, dmem_req}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bubble();
        dmem_rvalid = 1'b1;
        #1;
        chk("late_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("late_req", {31'd0, dmem_req}, 32'd0);
        chk("late_valid", {31'd0, valid_o}, 32'd0);
        chk("late_rdata", mem_rdata_o, 32'h0);
        drive(1'b1, 32'h0000_0304, 32'h0000_0077, 32'h0, 5'd2, 1'b1, WB_ALU, 1'b0, F3_W);
        #1;
        chk("post_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("post_valid", {31'd0, valid_o}, 32'd1);
        chk("post_alu", alu_out_o, 32'h0000_0077);
        bubble();
        mem_txn("post_lw", 1'b0, F3_W, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 0, 3,
                32'h0000_6000, 4'h0, 32'h0, 32'h1357_9BDF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
